// File: rtl/dshot_frame_tx.sv
// DSHOT150 frame serializer for a single motor channel.
//
// Takes the latest 12-bit value written by the register block ({telem,
// throttle[10:0]}), builds the 16-bit frame {throttle, telem, crc4} and
// drives it MSB first as pulse-width-coded bits on the motor pin. After the
// first write the latest value is re-sent continuously, with a guard gap
// between frames, for as long as i_enable is high.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_wr_stb       one-cycle strobe, latches i_value as the pending value
//   i_value        [10:0] throttle, [11] telemetry request
//   i_enable       1 = frames may start
//   o_motor        DSHOT line, idle low
//   o_busy         high while a frame or its gap is in progress
//   o_frame_done   one-cycle pulse on the last cycle of a frame's last bit
//   o_armed        high once any value has been written
module dshot_frame_tx #(
  parameter int BIT_CYCLES = 480,
  parameter int T1H_CYCLES = 360,
  parameter int T0H_CYCLES = 180,
  parameter int GAP_CYCLES = 1440
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_stb,
  input  logic [11:0] i_value,
  input  logic        i_enable,
  output logic        o_motor,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_armed
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYCLES);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [11:0]   pend_q;
  logic [15:0]   shift_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cyc_q;
  logic [GW-1:0] gap_q;
  logic          motor_q;
  logic          busy_q;
  logic          done_q;
  logic          armed_q;

  logic [CW-1:0] cyc_d;
  logic [CW-1:0] thr_d;
  logic [15:0]   load_d;

  // The register value carries telemetry in bit 11; on the wire it follows
  // the throttle, so the word is rotated before the nibble-fold CRC.
  function automatic logic [15:0] build_frame(input logic [11:0] val);
    logic [11:0] v;
    logic [3:0]  crc;
    v   = {val[10:0], val[11]};
    crc = v[3:0] ^ v[7:4] ^ v[11:8];
    return {v, crc};
  endfunction

  always_comb begin
    cyc_d  = cyc_q + 1'b1;
    thr_d  = shift_q[15] ? T1H_C : T0H_C;
    // A write in the load cycle itself is the freshest value: bypass pend_q.
    load_d = build_frame(i_wr_stb ? i_value : pend_q);
  end

  // o_motor is registered, so each assignment below sets the level for the
  // cycle index being entered, not the one being left.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      motor_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (i_wr_stb) begin
        pend_q  <= i_value;
        armed_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (armed_q && i_enable) begin
            shift_q <= load_d;
            bit_q   <= 4'd15;
            cyc_q   <= '0;
            motor_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_BIT;
          end
        end

        S_BIT: begin
          if (cyc_q == CYC_LAST) begin
            if (bit_q == 4'd0) begin
              gap_q   <= '0;
              motor_q <= 1'b0;
              state_q <= S_GAP;
            end else begin
              bit_q   <= bit_q - 1'b1;
              shift_q <= {shift_q[14:0], 1'b0};
              cyc_q   <= '0;
              motor_q <= 1'b1;
            end
          end else begin
            cyc_q   <= cyc_d;
            motor_q <= (cyc_d < thr_d);
            // Lines the pulse up with the final cycle of bit 0.
            if ((cyc_d == CYC_LAST) && (bit_q == 4'd0)) begin
              done_q <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          motor_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_motor      = motor_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_armed      = armed_q;

endmodule

// File: tb/tb_dshot_frame_tx.sv
// Testbench for dshot_frame_tx. A monitor decodes every complete frame from
// the motor pin (bit = high time above 270 cycles, i.e. 3750 ns at 72 MHz)
// and queues it; scenario tasks push expected frames as they drive writes
// and compare when the monitor delivers a frame.
`timescale 1ns/1ps
module tb_dshot_frame_tx;

  localparam int BITC = 480;
  localparam int T1H  = 360;
  localparam int T0H  = 180;
  localparam int GAPC = 1440;
  localparam int THR  = 270;

  logic        clk;
  logic        rst;
  logic        wr_stb;
  logic [11:0] value;
  logic        enable;
  logic        motor;
  logic        busy;
  logic        frame_done;
  logic        armed;

  int errors = 0;
  int checks = 0;

  dshot_frame_tx #(
    .BIT_CYCLES(BITC),
    .T1H_CYCLES(T1H),
    .T0H_CYCLES(T0H),
    .GAP_CYCLES(GAPC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_stb    (wr_stb),
    .i_value     (value),
    .i_enable    (enable),
    .o_motor     (motor),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_armed     (armed)
  );

  initial begin
    clk = 1'b0;
    forever #7 clk = ~clk;
  end

  typedef struct {
    logic [15:0] bits;
    int          rise;
    int          low_before;
    int          bad_w;
    int          bad_p;
  } frame_rec_t;

  frame_rec_t  obs_q[$];
  logic [15:0] exp_q[$];

  // ---------------- monitor ----------------
  int         mon_cyc = 0;
  int         mon_bits = 0;
  int         mon_hi = 0;
  int         mon_last_rise = 0;
  int         mon_last_fall = 0;
  int         done_total = 0;
  logic       mon_prev = 1'b0;
  frame_rec_t cur;

  always @(negedge clk) begin
    mon_cyc++;
    if (rst) begin
      mon_bits = 0;
      mon_hi   = 0;
      mon_prev = 1'b0;
    end else begin
      if (frame_done) done_total++;
      if (motor) begin
        if (!mon_prev) begin
          if (mon_bits == 0) begin
            cur.rise       = mon_cyc;
            cur.low_before = mon_cyc - mon_last_fall;
            cur.bits       = '0;
            cur.bad_w      = 0;
            cur.bad_p      = 0;
          end else if (mon_cyc - mon_last_rise != BITC) begin
            cur.bad_p++;
          end
          mon_last_rise = mon_cyc;
          mon_hi = 1;
        end else begin
          mon_hi++;
        end
      end else if (mon_prev) begin
        cur.bits = {cur.bits[14:0], (mon_hi > THR)};
        if (mon_hi != ((mon_hi > THR) ? T1H : T0H)) cur.bad_w++;
        mon_bits++;
        if (mon_bits == 16) begin
          obs_q.push_back(cur);
          mon_bits = 0;
          mon_last_fall = mon_cyc;
        end
      end
      mon_prev = motor;
    end
  end

  // ---------------- helpers ----------------
  function automatic int exp_frame(input int val);
    int thr, tel, v, crc;
    thr = val & 'h7FF;
    tel = (val >> 11) & 1;
    v   = thr * 2 + tel;
    crc = (v ^ (v >> 4) ^ (v >> 8)) & 'hF;
    return v * 16 + crc;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] v);
    wr_stb = 1'b1;
    value  = v;
    tick(1);
    wr_stb = 1'b0;
  endtask

  task automatic wait_rise(input string name, input int budget);
    int n;
    n = 0;
    while (motor !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (motor !== 1'b1) begin
      errors++;
      $display("FAIL %s: no rising edge within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_frame(input string name, output frame_rec_t rec);
    int n;
    logic [15:0] e;
    n = 0;
    rec.bits = '0; rec.rise = 0; rec.low_before = 0; rec.bad_w = 0; rec.bad_p = 0;
    while (obs_q.size() == 0 && n < 20000) begin
      tick(1);
      n++;
    end
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL %s_timeout: no frame within %0d cycles", name, n);
      return;
    end
    rec = obs_q.pop_front();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    if (rec.bits !== e) begin
      errors++;
      $display("FAIL %s_bits: got %h expected %h", name, rec.bits, e);
    end
    checks++;
    if (rec.bad_w !== 0) begin
      errors++;
      $display("FAIL %s_width: %0d pulses not %0d/%0d cycles", name, rec.bad_w, T0H, T1H);
    end
    checks++;
    if (rec.bad_p !== 0) begin
      errors++;
      $display("FAIL %s_bitper: %0d bit periods not %0d cycles", name, rec.bad_p, BITC);
    end
  endtask

  frame_rec_t f1, f2;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; wr_stb = 1'b0; value = '0; enable = 1'b1;
    tick(3);
    checks++; if (motor !== 1'b0) begin errors++; $display("FAIL rst_motor: got %b expected 0", motor); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", frame_done); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rst_armed: got %b expected 0", armed); end
    rst = 1'b0;
    tick(5);
    checks++; if (motor !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL unarmed_idle: motor=%b busy=%b expected 0 0", motor, busy); end
  endtask

  task automatic test_single_frame();
    exp_q.push_back(16'(exp_frame(12'h030)));
    do_write(12'h030);
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL s1_armed: got %b expected 1", armed); end
    wait_frame("s1", f1);
    checks++; if (f1.bits !== 16'h0606) begin errors++; $display("FAIL s1_literal: got %h expected 0606", f1.bits); end
    tick(400);
    checks++; if (done_total !== 1) begin errors++; $display("FAIL s1_done: got %0d pulses expected 1", done_total); end
  endtask

  task automatic test_repeat();
    exp_q.push_back(16'(exp_frame(12'h030)));
    wait_frame("s2", f2);
    checks++; if (f2.rise - f1.rise !== 16 * BITC + GAPC + 1) begin errors++; $display("FAIL s2_period: got %0d expected %0d", f2.rise - f1.rise, 16 * BITC + GAPC + 1); end
    checks++; if (f2.low_before < GAPC) begin errors++; $display("FAIL s2_gap: got %0d low cycles expected >= %0d", f2.low_before, GAPC); end
    tick(400);
    checks++; if (done_total !== 2) begin errors++; $display("FAIL s2_done: got %0d pulses expected 2", done_total); end
  endtask

  task automatic test_last_write_wins();
    frame_rec_t r;
    wait_rise("s3_start", 4000);
    exp_q.push_back(16'(exp_frame(12'h030)));
    exp_q.push_back(16'(exp_frame(12'h830)));
    tick(3000);
    do_write(12'h416);
    tick(2000);
    do_write(12'h830);
    wait_frame("s3_cur", r);
    wait_frame("s3_next", r);
    checks++; if (r.bits !== 16'h0617) begin errors++; $display("FAIL s3_literal: got %h expected 0617", r.bits); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    wait_rise("s4_start", 4000);
    tick(8 * BITC + 50);
    checks++; if (motor !== 1'b1) begin errors++; $display("FAIL s4_bit7_high: got %b expected 1", motor); end
    #2 rst = 1'b1;
    #1;
    checks++; if (motor !== 1'b0) begin errors++; $display("FAIL s4_async_motor: got %b expected 0", motor); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL s4_armed: got %b expected 0", armed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s4_busy: got %b expected 0", busy); end
    tick(3);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (motor !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL s4_quiet: got %0d active cycles expected 0", bad); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL s4_partial: got %0d frames expected 0", obs_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_enable_gate();
    int bad, n;
    enable = 1'b0;
    tick(2);
    do_write(12'h030);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (motor !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL s5_gated: got %0d high cycles expected 0", bad); end
    checks++; if (armed !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL s5_state: armed=%b busy=%b expected 1 0", armed, busy); end
    exp_q.push_back(16'(exp_frame(12'h030)));
    enable = 1'b1;
    n = 0;
    while (motor !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    checks++; if (n < 1 || n > 2) begin errors++; $display("FAIL s5_latency: got %0d cycles expected 1..2", n); end
  endtask

  task automatic test_enable_drop();
    frame_rec_t r;
    int n, bad;
    tick(12 * BITC + 50);
    enable = 1'b0;
    wait_frame("s6", r);
    checks++; if (r.bits !== 16'h0606) begin errors++; $display("FAIL s6_literal: got %h expected 0606", r.bits); end
    n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    n = 0;
    do begin
      tick(1);
      n++;
    end while (busy === 1'b1 && n < 5000);
    checks++; if (n !== GAPC + 1) begin errors++; $display("FAIL s6_gap: got %0d busy cycles after done expected %0d", n, GAPC + 1); end
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (motor !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL s6_stopped: got %0d active cycles expected 0", bad); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL s6_extra: got %0d frames expected 0", obs_q.size()); end
    enable = 1'b1;
    n = 0;
    while (motor !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    checks++; if (n < 1 || n > 2) begin errors++; $display("FAIL s6_resume: got %0d cycles expected 1..2", n); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_repeat();
    test_last_write_wins();
    test_reset_mid_frame();
    test_enable_gate();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
